// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus operand/result bus between the issue controller and the ALU.
// The controller takes the slave view; the environment (ALU and instruction source) the master.
interface alu_issue_ctrl_if #(
  parameter int unsigned W = 16
);
  logic         instr_valid;
  logic         instr_ready;
  logic [W-1:0] instr;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic         alu_cin;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_res;
  logic [W-1:0] alu_res_hi;
  logic         alu_cout;
  logic         alu_ovf;

  modport slave (
    input  instr_valid, instr, alu_res, alu_res_hi, alu_cout, alu_ovf,
    output instr_ready, alu_a, alu_b, alu_cin, alu_sel
  );

  modport master (
    output instr_valid, instr, alu_res, alu_res_hi, alu_cout, alu_ovf,
    input  instr_ready, alu_a, alu_b, alu_cin, alu_sel
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Serial issue controller for a 16-bit combinational ALU: accepts one instruction, reads its
// operands from an 8x16 register file, presents them to the ALU and writes the result(s) back.
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus,
  output logic            done,
  output logic [3:0]      flags,
  input  logic [2:0]      dbg_addr,
  output logic [W-1:0]    dbg_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StExec = 2'd2;
  localparam logic [1:0] StWbHi = 2'd3;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpMul = 4'd1;
  localparam logic [3:0] OpDiv = 4'd2;
  localparam logic [3:0] OpNot = 4'd6;
  localparam logic [3:0] OpAdc = 4'd7;

  logic [1:0]   r_state;
  logic [W-1:0] r_instr;
  logic [W-1:0] r_regs [NREGS];
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic         r_alu_cin;
  logic [3:0]   r_alu_sel;
  logic         r_done;
  logic         r_carry;
  logic         r_ovf;
  logic         r_div_zero;
  logic         r_illegal;

  logic [3:0]   w_op;
  logic [2:0]   w_rd;
  logic [2:0]   w_rd_hi;
  logic [2:0]   w_rs1;
  logic [2:0]   w_rs2;
  logic         w_illegal_op;
  logic         w_div_by_zero;
  logic         w_needs_hi;
  logic [3:0]   w_sel;
  logic         w_rf_we;
  logic [2:0]   w_rf_addr;
  logic [W-1:0] w_rf_data;
  logic         w_unused_instr;

  assign w_op           = r_instr[15:12];
  assign w_rd           = r_instr[11:9];
  assign w_rs1          = r_instr[8:6];
  assign w_rs2          = r_instr[5:3];
  assign w_rd_hi        = w_rd + 3'd1;
  assign w_unused_instr = ^r_instr[2:0];

  assign w_illegal_op  = w_op[3];
  assign w_div_by_zero = (r_alu_b == '0);
  assign w_needs_hi    = (w_op == OpMul) || ((w_op == OpDiv) && !w_div_by_zero);
  // ADC runs on the adder (select 0); opcodes 0..6 map straight onto the ALU select.
  assign w_sel         = (w_illegal_op || (w_op == OpAdc)) ? OpAdd : w_op;

  always_comb begin
    w_rf_we   = 1'b0;
    w_rf_addr = w_rd;
    w_rf_data = bus.alu_res;
    case (r_state)
      StExec: begin
        w_rf_we = 1'b1;
        // Division by zero writes all ones regardless of what the ALU returns.
        if ((w_op == OpDiv) && w_div_by_zero) begin
          w_rf_data = '1;
        end
      end
      StWbHi: begin
        w_rf_we   = 1'b1;
        w_rf_addr = w_rd_hi;
        w_rf_data = bus.alu_res_hi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_regs[w_rf_addr] <= w_rf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_instr    <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_cin  <= 1'b0;
      r_alu_sel  <= 4'd0;
      r_done     <= 1'b0;
      r_carry    <= 1'b0;
      r_ovf      <= 1'b0;
      r_div_zero <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.instr_valid) begin
            r_instr <= bus.instr;
            r_state <= StRead;
          end
        end

        StRead: begin
          r_alu_a   <= r_regs[w_rs1];
          r_alu_b   <= r_regs[w_rs2];
          r_alu_sel <= w_sel;
          r_alu_cin <= (w_op == OpAdc) && r_carry;
          if (w_illegal_op) begin
            r_illegal <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_state <= StExec;
          end
        end

        StExec: begin
          case (w_op)
            OpAdd, OpAdc: begin
              r_carry    <= bus.alu_cout;
              r_ovf      <= bus.alu_ovf;
              r_div_zero <= 1'b0;
              r_illegal  <= 1'b0;
            end
            OpMul: ;
            OpDiv: begin
              if (w_div_by_zero) begin
                r_div_zero <= 1'b1;
                r_illegal  <= 1'b0;
              end
            end
            default: begin
              r_div_zero <= 1'b0;
              r_illegal  <= 1'b0;
            end
          endcase
          if (w_needs_hi) begin
            r_state <= StWbHi;
          end else begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end

        StWbHi: begin
          r_div_zero <= 1'b0;
          r_illegal  <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= StIdle;
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == StIdle);
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_cin     = r_alu_cin;
  assign bus.alu_sel     = r_alu_sel;

  assign done     = r_done;
  assign flags    = {r_illegal, r_div_zero, r_ovf, r_carry};
  assign dbg_data = r_regs[dbg_addr];

endmodule
